// File: rtl/conv_maxpool_2x2_pkg.sv
// Shared definitions for the pooling stage: pixel geometry defaults that
// match the convolution unit, and a signed per-channel max helper.
package conv_maxpool_2x2_pkg;

  localparam int POOL_CH_NUM     = 18;
  localparam int POOL_DATA_WIDTH = 8;

  typedef logic [POOL_DATA_WIDTH-1:0] chan_t;

  // Signed two's-complement max of one channel; ties return either operand,
  // which is the same value.
  function automatic chan_t ch_max(input chan_t a, input chan_t b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/conv_maxpool_2x2_line_buf.sv
// Simple dual-port line buffer holding one horizontal-max pixel per window
// column. Synchronous write, registered read, maps onto block RAM.
module pool_line_buf #(
  parameter int DEPTH = 159,
  parameter int WIDTH = 144,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array write port.
  // NOTE: the storage array has no reset so synthesis can map it to block RAM;
  // its contents are never read before being written within a frame.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/conv_maxpool_2x2.sv
// Per-channel signed 2x2 / stride-2 max-pool on a raster pixel stream, with a
// per-frame bypass mode. Even rows store the horizontal max of each pair in a
// line buffer; odd rows combine it with their own pair max to emit a window.
module conv_maxpool_2x2
  import conv_maxpool_2x2_pkg::*;
#(
  parameter int CH_NUM     = POOL_CH_NUM,
  parameter int DATA_WIDTH = POOL_DATA_WIDTH,
  parameter int IMG_WIDTH  = 318,
  parameter int IMG_HEIGHT = 318,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CH_NUM*DATA_WIDTH-1:0] pool_data_in,
  input  logic                         pool_valid_in,
  input  logic                         pool_bypass,
  input  logic                         pool_clr,
  output logic [CH_NUM*DATA_WIDTH-1:0] pool_data_out,
  output logic                         pool_valid_out,
  output logic                         frame_done
);

  localparam int PIX_W    = CH_NUM * DATA_WIDTH;
  localparam int LB_DEPTH = IMG_WIDTH / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMG_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [CNT_WIDTH-1:0] LB_LIMIT = CNT_WIDTH'(LB_DEPTH);

  logic [CNT_WIDTH-1:0] col;
  logic [CNT_WIDTH-1:0] row;
  logic [CNT_WIDTH-1:0] col_half;
  logic                 bypass_r;
  logic [PIX_W-1:0]     hold;
  logic [PIX_W-1:0]     hmax;
  logic [PIX_W-1:0]     wmax;
  logic [PIX_W-1:0]     lb_rd;
  logic [LB_AW-1:0]     lb_addr;
  logic                 accept;
  logic                 col_wrap;
  logic                 frame_end;
  logic                 lb_we;
  logic                 lb_re;
  logic                 win_out;

  // pool_clr wins over a pixel presented in the same cycle.
  assign accept    = pool_valid_in & ~pool_clr;
  assign col_wrap  = (col == COL_LAST);
  assign frame_end = col_wrap & (row == ROW_LAST);
  assign col_half  = col >> 1;
  assign lb_addr   = col_half[LB_AW-1:0];

  // Odd column of an even row: store the pair max. Even column of an odd row:
  // prefetch the stored pair max so it is registered by the odd column. The
  // last column of an odd-width row has no buffer slot and is skipped.
  assign lb_we   = accept & ~bypass_r & col[0] & ~row[0];
  assign lb_re   = accept & ~bypass_r & ~col[0] & row[0] & (col_half < LB_LIMIT);
  assign win_out = accept & col[0] & row[0];

  // Per-channel signed max: pair max of the current row, then window max.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    hmax = '0;
    wmax = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      hmax[k*DATA_WIDTH +: DATA_WIDTH] = ch_max(hold[k*DATA_WIDTH +: DATA_WIDTH],
                                                pool_data_in[k*DATA_WIDTH +: DATA_WIDTH]);
      wmax[k*DATA_WIDTH +: DATA_WIDTH] = ch_max(lb_rd[k*DATA_WIDTH +: DATA_WIDTH],
                                                hmax[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Raster position counters; both wrap at the last pixel of the frame.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (pool_clr) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_wrap) begin
        col <= '0;
        row <= frame_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Mode is captured only while idle at the frame origin and then frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bypass_r <= 1'b0;
    end else if (!accept && (row == '0) && (col == '0)) begin
      bypass_r <= pool_bypass;
    end
  end

  // Left pixel of each horizontal pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (pool_clr) begin
      hold <= '0;
    end else if (accept && !col[0]) begin
      hold <= pool_data_in;
    end
  end

  // Output register: pass-through in bypass, window max otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pool_data_out  <= '0;
      pool_valid_out <= 1'b0;
      frame_done     <= 1'b0;
    end else if (pool_clr) begin
      pool_valid_out <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= accept & frame_end;
      if (bypass_r) begin
        pool_data_out  <= pool_data_in;
        pool_valid_out <= pool_valid_in;
      end else begin
        pool_valid_out <= win_out;
        if (win_out) begin
          pool_data_out <= wmax;
        end
      end
    end
  end

  pool_line_buf #(
    .DEPTH (LB_DEPTH),
    .WIDTH (PIX_W),
    .AW    (LB_AW)
  ) u_line_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (hmax),
    .re    (lb_re),
    .raddr (lb_addr),
    .rdata (lb_rd)
  );

endmodule

// File: tb/tb_conv_maxpool_2x2.sv
// Self-checking bench for conv_maxpool_2x2: a 4x4 and a 5x5 instance, random
// frames scored against a window-level reference model.
module tb_conv_maxpool_2x2;

  localparam int CH = 18;
  localparam int DW = 8;
  localparam int PW = CH * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] din;
  logic          vin, byp, clr;
  bit            sel;  // 0: 4x4 instance, 1: 5x5 instance

  logic          vin4, clr4, vin5, clr5;
  logic [PW-1:0] dout4, dout5, dout_s;
  logic          vout4, vout5, fd4, fd5, vout_s, fd_s;

  assign vin4   = sel ? 1'b0 : vin;
  assign clr4   = sel ? 1'b0 : clr;
  assign vin5   = sel ? vin : 1'b0;
  assign clr5   = sel ? clr : 1'b0;
  assign dout_s = sel ? dout5 : dout4;
  assign vout_s = sel ? vout5 : vout4;
  assign fd_s   = sel ? fd5 : fd4;

  conv_maxpool_2x2 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut4 (
    .clk(clk), .rst(rst), .pool_data_in(din), .pool_valid_in(vin4),
    .pool_bypass(byp), .pool_clr(clr4), .pool_data_out(dout4),
    .pool_valid_out(vout4), .frame_done(fd4)
  );

  conv_maxpool_2x2 #(.IMG_WIDTH(5), .IMG_HEIGHT(5)) u_dut5 (
    .clk(clk), .rst(rst), .pool_data_in(din), .pool_valid_in(vin5),
    .pool_bypass(byp), .pool_clr(clr5), .pool_data_out(dout5),
    .pool_valid_out(vout5), .frame_done(fd5)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0] frame[$];
  int            pres[$];
  logic [PW-1:0] out_q[$];
  int            out_cyc[$];
  int            done_cyc[$];
  logic [PW-1:0] exp_q[$];
  int            exp_cyc[$];
  logic [PW-1:0] nostall_q[$];

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (vout_s) begin
        out_q.push_back(dout_s);
        out_cyc.push_back(cyc);
      end
      if (fd_s) done_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    out_q.delete(); out_cyc.delete(); done_cyc.delete();
    exp_q.delete(); exp_cyc.delete(); pres.delete();
  endtask

  function automatic logic [PW-1:0] rand_pix();
    logic [PW-1:0] p;
    for (int k = 0; k < CH; k++) begin
      case ($urandom_range(0, 5))
        0:       p[k*DW +: DW] = 8'h80;
        1:       p[k*DW +: DW] = 8'h7F;
        default: p[k*DW +: DW] = 8'($urandom);
      endcase
    end
    return p;
  endfunction

  task automatic build_rand(input int w, input int h);
    frame.delete();
    for (int i = 0; i < w * h; i++) frame.push_back(rand_pix());
  endtask

  // Signed max of four pixels, channel by channel.
  function automatic logic [PW-1:0] max4(input logic [PW-1:0] a, b, c, d);
    logic [PW-1:0] r;
    int v[4];
    int m;
    for (int k = 0; k < CH; k++) begin
      v[0] = int'($signed(a[k*DW +: DW]));
      v[1] = int'($signed(b[k*DW +: DW]));
      v[2] = int'($signed(c[k*DW +: DW]));
      v[3] = int'($signed(d[k*DW +: DW]));
      m = v[0];
      for (int j = 1; j < 4; j++) if (v[j] > m) m = v[j];
      r[k*DW +: DW] = 8'(m);
    end
    return r;
  endfunction

  task automatic expect_pool(input int w, input int h);
    for (int wr = 0; wr < h / 2; wr++)
      for (int wc = 0; wc < w / 2; wc++) begin
        int tl;
        tl = 2 * wr * w + 2 * wc;
        exp_q.push_back(max4(frame[tl], frame[tl + 1], frame[tl + w], frame[tl + w + 1]));
        exp_cyc.push_back(pres[tl + w + 1] + 1);
      end
  endtask

  task automatic expect_bypass(input int w, input int h);
    for (int i = 0; i < w * h; i++) begin
      exp_q.push_back(frame[i]);
      exp_cyc.push_back(pres[i] + 1);
    end
  endtask

  task automatic present(input int i);
    din = frame[i];
    vin = 1'b1;
    pres.push_back(cyc);
    step();
    vin = 1'b0;
  endtask

  // Idle cycle first so the mode is captured at the frame origin; mode input
  // flips at pixel toggle_at to show it is ignored mid-frame.
  task automatic send_frame(input int w, input int h, input bit bp,
                            input int max_gap, input int toggle_at);
    byp = bp; vin = 1'b0; clr = 1'b0;
    step();
    for (int i = 0; i < w * h; i++) begin
      repeat ($urandom_range(0, max_gap)) step();
      if (i == toggle_at) byp = ~bp;
      present(i);
    end
    repeat (3) step();
    byp = bp;
  endtask

  task automatic compare(input string tag, input int w, input int h);
    int n;
    check({tag, "_count"}, PW'(out_q.size()), PW'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), out_q[i], exp_q[i]);
      check($sformatf("%s_cyc%0d", tag, i), PW'(out_cyc[i]), PW'(exp_cyc[i]));
    end
    check({tag, "_done_count"}, PW'(done_cyc.size()), PW'(1));
    if (done_cyc.size() > 0)
      check({tag, "_done_cyc"}, PW'(done_cyc[0]), PW'(pres[w * h - 1] + 1));
    clear_obs();
  endtask

  initial begin
    logic [7:0] v;
    logic [PW-1:0] exp_sig;
    int ramp_exp[4] = '{5, 7, 13, 15};

    rst = 1'b1; din = '0; vin = 1'b0; byp = 1'b0; clr = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout4", dout4, '0);
    check("rst_vout4", PW'(vout4), '0);
    check("rst_fd4", PW'(fd4), '0);
    check("rst_dout5", dout5, '0);
    check("rst_vout5", PW'(vout5), '0);
    rst = 1'b0;
    step();
    clear_obs();

    // 4x4 ramp: every channel of pixel (r,c) = r*4+c.
    frame.delete();
    for (int i = 0; i < 16; i++) begin
      v = 8'(i);
      frame.push_back({CH{v}});
    end
    send_frame(4, 4, 1'b0, 0, -1);
    for (int i = 0; i < 4; i++) begin
      v = 8'(ramp_exp[i]);
      check($sformatf("ramp_const%0d", i), (i < out_q.size()) ? out_q[i] : 'x, {CH{v}});
    end
    expect_pool(4, 4);
    compare("ramp", 4, 4);

    // Signed window: ch0 {-128,-1,-5,-128} -> -1, ch1 {127,-128,0,0} -> 127.
    build_rand(4, 4);
    frame[0] = '0; frame[1] = '0; frame[4] = '0; frame[5] = '0;
    frame[0][7:0] = 8'h80; frame[1][7:0] = 8'hFF; frame[4][7:0] = 8'hFB; frame[5][7:0] = 8'h80;
    frame[0][15:8] = 8'h7F; frame[1][15:8] = 8'h80;
    send_frame(4, 4, 1'b0, 1, -1);
    exp_sig = '0;
    exp_sig[15:0] = 16'h7FFF;
    check("signed_win", (out_q.size() > 0) ? out_q[0] : 'x, exp_sig);
    expect_pool(4, 4);
    compare("signed", 4, 4);

    // Random 4x4 frames with stalls.
    for (int t = 0; t < 3; t++) begin
      build_rand(4, 4);
      send_frame(4, 4, 1'b0, 3, -1);
      expect_pool(4, 4);
      compare($sformatf("rand%0d", t), 4, 4);
    end

    // 5x5: last row and column ignored; stalls do not change results.
    sel = 1'b1;
    step();
    build_rand(5, 5);
    send_frame(5, 5, 1'b0, 0, -1);
    nostall_q = out_q;
    expect_pool(5, 5);
    compare("odd_nostall", 5, 5);
    send_frame(5, 5, 1'b0, 3, -1);
    for (int i = 0; i < 4; i++)
      check($sformatf("odd_same%0d", i), (i < out_q.size()) ? out_q[i] : 'x,
            (i < nostall_q.size()) ? nostall_q[i] : '0);
    expect_pool(5, 5);
    compare("odd_stall", 5, 5);
    sel = 1'b0;
    step();
    clear_obs();

    // Bypass frame, mode input dropped mid-frame; then a pool frame with the
    // mode input raised mid-frame.
    build_rand(4, 4);
    send_frame(4, 4, 1'b1, 2, 7);
    expect_bypass(4, 4);
    compare("bypass", 4, 4);
    build_rand(4, 4);
    send_frame(4, 4, 1'b0, 2, 5);
    expect_pool(4, 4);
    compare("after_bypass", 4, 4);

    // Abort with pool_clr on the 6th pixel (bottom-right of first window).
    build_rand(4, 4);
    byp = 1'b0;
    step();
    for (int i = 0; i < 5; i++) present(i);
    din = frame[5]; vin = 1'b1; clr = 1'b1;
    step();
    vin = 1'b0; clr = 1'b0;
    repeat (3) step();
    check("clr_no_out", PW'(out_q.size()), '0);
    check("clr_no_done", PW'(done_cyc.size()), '0);
    clear_obs();
    build_rand(4, 4);
    send_frame(4, 4, 1'b0, 1, -1);
    expect_pool(4, 4);
    compare("after_clr", 4, 4);

    // Asynchronous reset mid-row while an output is being shown.
    build_rand(4, 4);
    step();
    for (int i = 0; i < 6; i++) present(i);
    check("rst_pre_valid", PW'(vout4), PW'(1));
    din = frame[6]; vin = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_async_vout", PW'(vout4), '0);
    check("rst_async_dout", dout4, '0);
    vin = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    clear_obs();
    build_rand(4, 4);
    send_frame(4, 4, 1'b0, 2, -1);
    expect_pool(4, 4);
    compare("after_rst", 4, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_maxpool_2x2.md
Name: conv_maxpool_2x2

Overview:
- Downstream stage of the convolution unit.
- Consumes the 18-channel, 8-bit-per-channel output pixel stream in raster order.
- Performs a per-channel signed 2x2 max-pool with stride 2, producing one output pixel per 2x2 window.
- A bypass mode passes pixels through unchanged, for layers without pooling.

Parameters:
- CH_NUM, 18, number of channels packed per pixel.
- DATA_WIDTH, 8, bits per channel, signed two's complement.
- IMG_WIDTH, 318, input pixels per row (2..1023).
- IMG_HEIGHT, 318, input rows per frame (2..1023).
- CNT_WIDTH, 10, width of the row and column counters.

Ports:
- clk, input, 1, clock; all logic is on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- pool_data_in, input, CH_NUM*DATA_WIDTH, input pixel; channel k is at bits [k*DATA_WIDTH +: DATA_WIDTH].
- pool_valid_in, input, 1, input pixel valid; there is no backpressure.
- pool_bypass, input, 1, 1 = pass-through; sampled only while the frame is idle (row=0, col=0).
- pool_clr, input, 1, synchronous restart of counters and state; takes priority over pool_valid_in.
- pool_data_out, output, CH_NUM*DATA_WIDTH, output pixel.
- pool_valid_out, output, 1, output pixel valid (one-cycle pulse per pixel).
- frame_done, output, 1, one-cycle pulse when the last input pixel of a frame is accepted.

Behaviour:
- Reset (rst high, asynchronous):
  - pool_data_out=0, pool_valid_out=0, frame_done=0.
  - col=0, row=0, bypass_r=0, hold register=0.
  - Line-buffer contents are don't-care.
- Counters:
  - col advances on each accepted pixel and wraps at IMG_WIDTH-1 to 0; row advances when col wraps.
  - When row=IMG_HEIGHT-1 and col=IMG_WIDTH-1 are accepted, both wrap to 0 and frame_done pulses in the following cycle.
- bypass_r is latched from pool_bypass on any cycle with row=0, col=0 and no accepted pixel. It holds for the whole frame.
- Bypass mode:
  - pool_data_out <= pool_data_in and pool_valid_out <= pool_valid_in, 1-cycle latency.
  - Counters still run, so frame_done still pulses.
- Pool mode, per accepted pixel at (row, col), using signed per-channel max:
  - Even col: hold <= pixel.
  - Odd col, even row: hmax = max(hold, pixel); write hmax into the line buffer at address col>>1.
  - Even col, odd row: hold <= pixel; issue a line-buffer read at address col>>1. Read data is registered and available next cycle.
  - Odd col, odd row: out = max(linebuf_rd, max(hold, pixel)). pool_data_out <= out and pool_valid_out <= 1 on the next edge.
- Latency: pool_valid_out rises exactly 1 cycle after the bottom-right pixel of a window is accepted.
- Output count per frame: floor(IMG_WIDTH/2) * floor(IMG_HEIGHT/2).
- Odd IMG_WIDTH: the last column of each row is latched into hold but never produces output or a buffer write.
- Odd IMG_HEIGHT: the last row is consumed (counters run) and produces no output.
- Gaps in pool_valid_in: any number of idle cycles between pixels is allowed. State holds, and the registered read data stays stable until the next accepted pixel.
- Ties: equal values output that value. -128 vs 127 gives 127 (signed compare, never unsigned).
- pool_clr:
  - Next edge: col=0, row=0, pool_valid_out=0.
  - A pixel presented in the same cycle is discarded.
  - frame_done does not pulse.
- rst mid-frame: all state is cleared; the next accepted pixel is treated as (0,0).
- Line buffer:
  - Depth IMG_WIDTH/2, width CH_NUM*DATA_WIDTH.
  - Write and read never target the same address in the same cycle, because writes occur only on even rows and reads only on odd rows.

Decomposition:
- Shared package:
  - CH_NUM and DATA_WIDTH defaults, shared with the conv unit.
  - A signed-max function over one channel.
- Sub-module pool_line_buf:
  - Simple dual-port RAM, synchronous write, registered read, depth and width parameterised.
  - Infers BRAM/DRM.
  - No reset on the array; the read data register is reset to 0.

Test Plan:
- 4x4 frame, all channels of pixel (r,c) = r*4+c, pool mode -> 4 outputs in order 5, 7, 13, 15 on every channel. Each valid pulse occurs 1 cycle after input (1,1), (1,3), (3,1), (3,3). frame_done pulses once, 1 cycle after (3,3).
- Signed check, 2x2 window with ch0 = {-128, -1, -5, -128} and ch1 = {127, -128, 0, 0} -> ch0 out = -1 (0xFF), ch1 out = 127 (0x7F). Other channels are 0 -> 0.
- 5x5 frame with random stalls (pool_valid_in low 0-3 cycles between pixels) -> exactly 4 outputs, matching a golden model. Row 4 and column 4 are ignored. Outputs are identical to the no-stall run.
- pool_bypass=1 at frame start, 4x4 frame -> 16 outputs equal to the inputs with 1-cycle latency. Toggling pool_bypass mid-frame has no effect until the next frame.
- pool_clr asserted after 6 pixels of a 4x4 frame (with a pixel present that cycle), then a fresh 4x4 frame -> no output from the aborted frame, no frame_done for it, and 4 correct outputs for the new frame.
- rst asserted asynchronously mid-row -> pool_valid_out and pool_data_out are 0 immediately. After release, a full 4x4 frame produces the correct 4 outputs.
